// File: rtl/flag_branch_resolver_pkg.sv
// Shared types for the flag/branch resolver: condition codes and flag bit positions.
package branch_pkg;

   typedef enum logic [2:0] {
      COND_AL = 3'd0,
      COND_EQ = 3'd1,
      COND_NE = 3'd2,
      COND_LT = 3'd3,
      COND_GE = 3'd4,
      COND_LE = 3'd5,
      COND_GT = 3'd6,
      COND_NV = 3'd7
   } cond_e;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;

endpackage

// File: rtl/flag_branch_resolver_if.sv
// Execute/decode/fetch side signals of the resolver; master drives requests and flags,
// slave is the resolver itself.
interface flag_branch_resolver_if #(
   parameter int ADDR_W = 32
);
   import branch_pkg::*;

   logic [1:0]        flags_in;
   logic              flags_we;
   logic              flag_issue;
   logic              flush;
   logic              br_valid;
   cond_e             br_cond;
   logic [ADDR_W-1:0] br_target;
   logic              br_ready;
   logic              issue_stall;
   logic              res_valid;
   logic              res_taken;
   logic [ADDR_W-1:0] res_target;
   logic [1:0]        flags_q;

   modport master (
      output flags_in, flags_we, flag_issue, flush, br_valid, br_cond, br_target,
      input  br_ready, issue_stall, res_valid, res_taken, res_target, flags_q
   );

   modport slave (
      input  flags_in, flags_we, flag_issue, flush, br_valid, br_cond, br_target,
      output br_ready, issue_stall, res_valid, res_taken, res_target, flags_q
   );

endinterface

// File: rtl/flag_branch_resolver_cond_eval.sv
// Combinational condition-code evaluation against {N,Z}; zero latency, no flow control.
module branch_cond_eval
   import branch_pkg::*;
(
   input  cond_e      cond,
   input  logic [1:0] flags,
   output logic       taken
);

   logic z;
   logic n;

   assign z = flags[FLAG_Z];
   assign n = flags[FLAG_N];

   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_AL: taken = 1'b1;
         COND_EQ: taken = z;
         COND_NE: taken = !z;
         COND_LT: taken = n;
         COND_GE: taken = !n;
         COND_LE: taken = z | n;
         COND_GT: taken = !z & !n;
         COND_NV: taken = 1'b0;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/flag_branch_resolver.sv
// Flag register + in-flight scoreboard; resolves branches on forwarded flags, result 1 cycle
// after accept. br_ready drops while older flag writers are outstanding or on flush.
module flag_branch_resolver
   import branch_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int PEND_W = 2
) (
   input logic                    clk,
   input logic                    rst_n,
   flag_branch_resolver_if.slave  bus
);

   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

   logic [PEND_W-1:0] pend_cnt;
   logic [PEND_W-1:0] pend_nxt;
   logic [1:0]        flags_r;
   logic [1:0]        eff_flags;
   logic              issue_ok;
   logic              accept;
   logic              taken;
   logic              res_valid_r;
   logic              res_taken_r;
   logic [ADDR_W-1:0] res_target_r;

   assign bus.issue_stall = (pend_cnt == PEND_MAX) && !bus.flags_we;
   // A branch may go only once its last older flag writer retires (possibly this cycle).
   assign bus.br_ready    = !bus.flush &&
                            ((pend_cnt == '0) || ((pend_cnt == PEND_ONE) && bus.flags_we));
   assign issue_ok  = bus.flag_issue && !bus.issue_stall;
   assign accept    = bus.br_valid && bus.br_ready;
   assign eff_flags = bus.flags_we ? bus.flags_in : flags_r;

   branch_cond_eval u_cond_eval (
      .cond  (bus.br_cond),
      .flags (eff_flags),
      .taken (taken)
   );

   always_comb begin
      pend_nxt = pend_cnt;
      if (bus.flush) begin
         pend_nxt = '0;
      end else if (issue_ok && !bus.flags_we) begin
         pend_nxt = pend_cnt + PEND_ONE;
      end else if (!issue_ok && bus.flags_we && (pend_cnt != '0)) begin
         pend_nxt = pend_cnt - PEND_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flags_r      <= '0;
         pend_cnt     <= '0;
         res_valid_r  <= 1'b0;
         res_taken_r  <= 1'b0;
         res_target_r <= '0;
      end else begin
         if (bus.flags_we) begin
            flags_r <= bus.flags_in;
         end
         pend_cnt    <= pend_nxt;
         res_valid_r <= accept;
         if (accept) begin
            res_taken_r  <= taken;
            res_target_r <= bus.br_target;
         end
      end
   end

   assign bus.flags_q    = flags_r;
   assign bus.res_valid  = res_valid_r;
   assign bus.res_taken  = res_taken_r;
   assign bus.res_target = res_target_r;

endmodule
